// File: rtl/axi4_sram_slave.sv
`timescale 1ns/1ps
// AXI4 slave backed by a byte-strobed on-chip SRAM.
// Independent read and write engines, one burst outstanding per direction.
module axi4_sram_slave #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ID_W-1:0]   s_awid,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic [2:0]        s_awsize,
    input  logic [1:0]        s_awburst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [1:0]        s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [ID_W-1:0]   s_rid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - LANE_W;
    localparam int WORDS  = 1 << IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    function automatic logic burst_err(input logic [1:0] burst,
                                       input logic [2:0] size);
        return (burst != BURST_FIXED && burst != BURST_INCR) ||
               (size != 3'(LANE_W));
    endfunction

    logic [DATA_W-1:0] mem [WORDS];

    // ---------------- write engine ----------------
    w_state_e          w_state_q, w_state_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [IDX_W-1:0]  w_idx_q, w_idx_d;
    logic [7:0]        w_len_q, w_len_d;
    logic [7:0]        w_cnt_q, w_cnt_d;
    logic              w_fixed_q, w_fixed_d;
    logic              w_err_q, w_err_d;
    logic              w_bad_q, w_bad_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              w_fire;
    logic              mem_we;

    assign w_fire = (w_state_q == W_DATA) && s_wvalid && wready_q;
    assign mem_we = w_fire && !w_err_q;

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_fixed_d = w_fixed_q;
        w_err_d   = w_err_q;
        w_bad_d   = w_bad_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (s_awvalid && awready_q) begin
                    w_id_d    = s_awid;
                    w_idx_d   = s_awaddr[ADDR_W-1:LANE_W];
                    w_len_d   = s_awlen;
                    w_cnt_d   = '0;
                    w_fixed_d = (s_awburst == BURST_FIXED);
                    w_err_d   = burst_err(s_awburst, s_awsize);
                    w_bad_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    if (!w_fixed_q) w_idx_d = w_idx_q + 1'b1;
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (s_wlast) begin
                        bid_d     = w_id_q;
                        bresp_d   = (w_err_q || w_bad_q || w_cnt_q != w_len_q)
                                  ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else if (w_cnt_q == w_len_q) begin
                        // burst ran past awlen+1 without wlast; sticky
                        w_bad_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && s_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_fixed_q <= 1'b0;
            w_err_q   <= 1'b0;
            w_bad_q   <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_fixed_q <= w_fixed_d;
            w_err_q   <= w_err_d;
            w_bad_q   <= w_bad_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_wstrb[b]) mem[w_idx_q][b*8 +: 8] <= s_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_e          r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [IDX_W-1:0]  r_idx_q, r_idx_d;
    logic [7:0]        r_len_q, r_len_d;
    logic [7:0]        r_cnt_q, r_cnt_d;
    logic              r_fixed_q, r_fixed_d;
    logic              r_err_q, r_err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;
    logic [IDX_W-1:0]  ar_idx;
    logic              ar_err;
    logic [IDX_W-1:0]  r_next_idx;

    assign ar_idx     = s_araddr[ADDR_W-1:LANE_W];
    assign ar_err     = burst_err(s_arburst, s_arsize);
    assign r_next_idx = r_fixed_q ? r_idx_q : r_idx_q + 1'b1;

    // rdata is captured from the array before any same-edge write lands
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_fixed_d = r_fixed_q;
        r_err_d   = r_err_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (s_arvalid && arready_q) begin
                    rid_d     = s_arid;
                    r_idx_d   = ar_idx;
                    r_len_d   = s_arlen;
                    r_cnt_d   = '0;
                    r_fixed_d = (s_arburst == BURST_FIXED);
                    r_err_d   = ar_err;
                    rdata_d   = ar_err ? '0 : mem[ar_idx];
                    rresp_d   = ar_err ? RESP_SLVERR : RESP_OKAY;
                    rlast_d   = (s_arlen == 8'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && s_rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d = r_next_idx;
                        r_cnt_d = r_cnt_q + 8'd1;
                        rdata_d = r_err_q ? '0 : mem[r_next_idx];
                        rlast_d = (r_cnt_q + 8'd1 == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_fixed_q <= 1'b0;
            r_err_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_fixed_q <= r_fixed_d;
            r_err_q   <= r_err_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_awaddr[LANE_W-1:0], s_araddr[LANE_W-1:0]};

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bid     = bid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rid     = rid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign s_rlast   = rlast_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
`timescale 1ns/1ps
// Randomized bench for axi4_sram_slave against a byte-array memory model.
module tb_axi4_sram_slave;

    localparam int LIM = 600;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  s_awid;
    logic [11:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_wvalid;
    logic        s_wready;
    logic [3:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [3:0]  s_arid;
    logic [11:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arvalid;
    logic        s_arready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;

    axi4_sram_slave #(.ADDR_W(12), .DATA_W(32), .ID_W(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] wd [0:511];
    logic [3:0]  ws [0:511];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int wi);
        return {ref_mem[wi*4+3], ref_mem[wi*4+2],
                ref_mem[wi*4+1], ref_mem[wi*4]};
    endfunction

    function automatic int beat_idx(input logic [11:0] addr,
                                    input logic [1:0] burst, input int k);
        if (burst == 2'b00) return int'(addr) / 4;
        return (int'(addr) / 4 + k) % 1024;
    endfunction

    task automatic do_write(input logic [11:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [3:0] id, input int nbeats);
        int t;
        int wi;
        logic err;
        logic [1:0] exp_resp;
        err = (burst > 2'b01) || (size != 3'd2);
        exp_resp = (err || nbeats != len + 1) ? 2'b10 : 2'b00;
        s_awid = id; s_awaddr = addr; s_awlen = 8'(len);
        s_awsize = size; s_awburst = burst; s_awvalid = 1'b1;
        t = 0;
        while (!s_awready && t < LIM) begin @(posedge aclk); #1; t++; end
        check("aw_timeout", 64'(t >= LIM), 64'(0));
        @(posedge aclk); #1;
        s_awvalid = 1'b0;
        check("wready_lat", 64'(s_wready), 64'(1));
        check("awready_busy", 64'(s_awready), 64'(0));
        for (int b = 0; b < nbeats; b++) begin
            s_wdata = wd[b]; s_wstrb = ws[b];
            s_wlast = (b == nbeats - 1); s_wvalid = 1'b1;
            t = 0;
            while (!s_wready && t < LIM) begin @(posedge aclk); #1; t++; end
            check("w_timeout", 64'(t >= LIM), 64'(0));
            @(posedge aclk); #1;
            if (!err) begin
                wi = beat_idx(addr, burst, b);
                for (int l = 0; l < 4; l++)
                    if (ws[b][l]) ref_mem[wi*4+l] = wd[b][l*8 +: 8];
            end
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        check("bvalid_lat", 64'(s_bvalid), 64'(1));
        check("bid", 64'(s_bid), 64'(id));
        check("bresp", 64'(s_bresp), 64'(exp_resp));
        s_bready = 1'b1;
        @(posedge aclk); #1;
        s_bready = 1'b0;
        check("bvalid_drop", 64'(s_bvalid), 64'(0));
    endtask

    // mode 0: rready held high, 1: alternate 1,0,1,0, 2: random
    task automatic do_read(input logic [11:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [3:0] id, input int mode);
        int t;
        int k;
        logic err;
        logic rr;
        logic tog;
        logic [31:0] exp_data;
        err = (burst > 2'b01) || (size != 3'd2);
        s_arid = id; s_araddr = addr; s_arlen = 8'(len);
        s_arsize = size; s_arburst = burst; s_arvalid = 1'b1;
        t = 0;
        while (!s_arready && t < LIM) begin @(posedge aclk); #1; t++; end
        check("ar_timeout", 64'(t >= LIM), 64'(0));
        @(posedge aclk); #1;
        s_arvalid = 1'b0;
        check("rvalid_lat", 64'(s_rvalid), 64'(1));
        check("arready_busy", 64'(s_arready), 64'(0));
        k = 0; t = 0; tog = 1'b1;
        while (k <= len && t < LIM) begin
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            s_rready = rr;
            if (s_rvalid) begin
                exp_data = err ? 32'h0 : ref_word(beat_idx(addr, burst, k));
                check($sformatf("rdata[%0d]", k), 64'(s_rdata), 64'(exp_data));
                check($sformatf("rresp[%0d]", k), 64'(s_rresp),
                      64'(err ? 2'b10 : 2'b00));
                check($sformatf("rlast[%0d]", k), 64'(s_rlast), 64'(k == len));
                check($sformatf("rid[%0d]", k), 64'(s_rid), 64'(id));
                if (rr) k++;
            end
            @(posedge aclk); #1;
            t++;
        end
        s_rready = 1'b0;
        check("r_timeout", 64'(t >= LIM), 64'(0));
        check("rvalid_end", 64'(s_rvalid), 64'(0));
        check("arready_back", 64'(s_arready), 64'(1));
    endtask

    initial begin
        int len;
        int nb;
        int r;
        logic [1:0] burst;
        logic [2:0] size;
        aresetn = 1'b0;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
        s_awburst = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
        s_arburst = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_awready", 64'(s_awready), 64'(0));
        check("rst_arready", 64'(s_arready), 64'(0));
        check("rst_outs", 64'({s_wready, s_bvalid, s_rvalid, s_rlast}), 64'(0));
        check("rst_bid_bresp", 64'({s_bid, s_bresp}), 64'(0));
        check("rst_rdata", 64'({s_rid, s_rresp, s_rdata}), 64'(0));
        aresetn = 1'b1;
        #1;
        check("rel_awready", 64'(s_awready), 64'(0));
        @(posedge aclk); #1;
        check("rise_awready", 64'(s_awready), 64'(1));
        check("rise_arready", 64'(s_arready), 64'(1));

        // fill the whole memory so the model is fully known
        for (int q = 0; q < 4; q++) begin
            for (int b = 0; b < 256; b++) begin
                wd[b] = $urandom; ws[b] = 4'hF;
            end
            do_write(12'(q * 1024), 255, 3'd2, 2'b01, 4'(q), 256);
        end

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(12'h010, 0, 3'd2, 2'b01, 4'h3, 1);
        do_read(12'h010, 0, 3'd2, 2'b01, 4'h5, 0);

        for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
        do_write(12'h100, 3, 3'd2, 2'b01, 4'h1, 4);
        do_read(12'h100, 3, 3'd2, 2'b01, 4'h2, 1);

        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        do_write(12'h200, 0, 3'd2, 2'b01, 4'h0, 1);
        wd[0] = 32'h00000000; ws[0] = 4'h5;
        do_write(12'h200, 0, 3'd2, 2'b01, 4'h0, 1);
        check("strb_model", 64'(ref_word(12'h200 / 4)), 64'(32'hFF00FF00));
        do_read(12'h200, 0, 3'd2, 2'b01, 4'h0, 0);

        for (int b = 0; b < 2; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        do_write(12'h100, 1, 3'd2, 2'b10, 4'h7, 2);
        do_read(12'h100, 1, 3'd2, 2'b01, 4'h7, 0);

        do_read(12'h100, 1, 3'd1, 2'b01, 4'h9, 0);

        for (int b = 0; b < 2; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        do_write(12'h300, 3, 3'd2, 2'b01, 4'hA, 2);
        do_read(12'h300, 3, 3'd2, 2'b01, 4'hA, 0);

        for (int b = 0; b < 2; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        do_write(12'hFFC, 1, 3'd2, 2'b01, 4'hB, 2);
        do_read(12'h000, 0, 3'd2, 2'b01, 4'hB, 0);
        do_read(12'hFFC, 1, 3'd2, 2'b01, 4'hB, 0);

        // reset during the second beat of a 4-beat read
        s_arid = 4'h6; s_araddr = 12'h100; s_arlen = 8'd3;
        s_arsize = 3'd2; s_arburst = 2'b01; s_arvalid = 1'b1;
        @(posedge aclk); #1;
        s_arvalid = 1'b0;
        s_rready = 1'b1;
        check("mid_beat1", 64'(s_rdata), 64'(ref_word(12'h100 / 4)));
        @(posedge aclk); #1;
        s_rready = 1'b0;
        check("mid_beat2", 64'(s_rdata), 64'(ref_word(12'h104 / 4)));
        aresetn = 1'b0;
        #1;
        check("mid_rvalid", 64'(s_rvalid), 64'(0));
        check("mid_rdata", 64'({s_rdata, s_rlast}), 64'(0));
        check("mid_arready", 64'(s_arready), 64'(0));
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("mid_arready_up", 64'(s_arready), 64'(1));
        check("mid_no_r", 64'(s_rvalid), 64'(0));
        do_read(12'h100, 3, 3'd2, 2'b01, 4'h6, 0);

        for (int it = 0; it < 60; it++) begin
            len = $urandom_range(0, 7);
            r = $urandom_range(0, 9);
            burst = (r <= 4) ? 2'b01 : (r <= 7) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1) * 2 + 1) : 3'd2;
            if ($urandom_range(0, 1) == 1) begin
                nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len + 3) : len + 1;
                for (int b = 0; b < nb; b++) begin
                    wd[b] = $urandom; ws[b] = 4'($urandom);
                end
                do_write(12'($urandom), len, size, burst, 4'($urandom), nb);
            end else begin
                do_read(12'($urandom), len, size, burst, 4'($urandom), 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
